speriph_plug_arbiter: RTL



---
 rtl/speriph_plug_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/speriph_plug_arbiter.sv
// N-to-1 peripheral plug combiner: round-robin request arbitration with hold under
// back-pressure, and an in-order FIFO that routes each response back to its requester.
module speriph_plug_arbiter #(
  parameter int NB_PLUGS        = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int ID_WIDTH        = 5,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                                       clk_i,
  input  logic                                       rst_i,
  input  logic [NB_PLUGS-1:0]                        s_req_i,
  input  logic [NB_PLUGS-1:0][ADDR_WIDTH-1:0]        s_add_i,
  input  logic [NB_PLUGS-1:0]                        s_wen_i,
  input  logic [NB_PLUGS-1:0][DATA_WIDTH-1:0]        s_wdata_i,
  input  logic [NB_PLUGS-1:0][DATA_WIDTH/8-1:0]      s_be_i,
  input  logic [NB_PLUGS-1:0][ID_WIDTH-1:0]          s_id_i,
  output logic [NB_PLUGS-1:0]                        s_gnt_o,
  output logic [NB_PLUGS-1:0]                        s_r_valid_o,
  output logic [DATA_WIDTH-1:0]                      s_r_rdata_o,
  output logic                                       s_r_opc_o,
  output logic [ID_WIDTH-1:0]                        s_r_id_o,
  output logic                                       m_req_o,
  output logic [ADDR_WIDTH-1:0]                      m_add_o,
  output logic                                       m_wen_o,
  output logic [DATA_WIDTH-1:0]                      m_wdata_o,
  output logic [DATA_WIDTH/8-1:0]                    m_be_o,
  output logic [ID_WIDTH-1:0]                        m_id_o,
  input  logic                                       m_gnt_i,
  input  logic                                       m_r_valid_i,
  input  logic [DATA_WIDTH-1:0]                      m_r_rdata_i,
  input  logic                                       m_r_opc_i,
  input  logic [ID_WIDTH-1:0]                        m_r_id_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]       outstanding_o,
  output logic                                       err_o
);

  localparam int PW = $clog2(NB_PLUGS);
  localparam int FW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT   = CW'(MAX_OUTSTANDING);
  localparam logic [FW-1:0] LAST_SLOT = FW'(MAX_OUTSTANDING - 1);

  logic [PW-1:0] rr_ptr_q;
  logic          hold_q;
  logic [PW-1:0] held_idx_q;
  logic [PW-1:0] fifo_q [MAX_OUTSTANDING];
  logic [FW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;
  logic          err_q;

  logic [PW-1:0] rr_sel, sel;
  logic          found, hold_live, can_push, handshake, push, pop, orphan;

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NB_PLUGS) s = s - NB_PLUGS;
    return s[PW-1:0];
  endfunction

  function automatic logic [FW-1:0] next_slot(input logic [FW-1:0] p);
    return (p == LAST_SLOT) ? '0 : p + FW'(1);
  endfunction

  // A held plug that drops its request loses the hold in the same cycle
  always_comb begin
    rr_sel    = rr_ptr_q;
    found     = 1'b0;
    for (int k = 0; k < NB_PLUGS; k++) begin
      if (!found && s_req_i[wrap_add(rr_ptr_q, k)]) begin
        found  = 1'b1;
        rr_sel = wrap_add(rr_ptr_q, k);
      end
    end
    hold_live = hold_q & s_req_i[held_idx_q];
    sel       = hold_live ? held_idx_q : rr_sel;
  end

  always_comb begin
    can_push  = (count_q < MAX_CNT) | m_r_valid_i;
    m_req_o   = (|s_req_i) & can_push;
    handshake = m_req_o & m_gnt_i;
    push      = handshake;
    pop       = m_r_valid_i & (count_q != '0);
    orphan    = m_r_valid_i & (count_q == '0);

    m_add_o   = '0;
    m_wen_o   = 1'b0;
    m_wdata_o = '0;
    m_be_o    = '0;
    m_id_o    = '0;
    if (m_req_o) begin
      m_add_o   = s_add_i[sel];
      m_wen_o   = s_wen_i[sel];
      m_wdata_o = s_wdata_i[sel];
      m_be_o    = s_be_i[sel];
      m_id_o    = s_id_i[sel];
    end

    s_gnt_o     = '0;
    s_r_valid_o = '0;
    for (int i = 0; i < NB_PLUGS; i++) begin
      s_gnt_o[i]     = handshake & (sel == PW'(i));
      s_r_valid_o[i] = pop & (fifo_q[head_q] == PW'(i));
    end
  end

  assign s_r_rdata_o   = m_r_rdata_i;
  assign s_r_opc_o     = m_r_opc_i;
  assign s_r_id_o      = m_r_id_i;
  assign outstanding_o = count_q;
  assign err_o         = err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q   <= '0;
      hold_q     <= 1'b0;
      held_idx_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      if (handshake) begin
        rr_ptr_q <= wrap_add(sel, 1);
        hold_q   <= 1'b0;
      end else if (m_req_o) begin
        hold_q     <= 1'b1;
        held_idx_q <= sel;
      end else if (!hold_live) begin
        hold_q <= 1'b0;
      end

      if (push) tail_q <= next_slot(tail_q);
      if (pop)  head_q <= next_slot(head_q);

      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);

      if (orphan) err_q <= 1'b1;
    end
  end

  // Slot contents need no reset: they are only read while the count says they are valid
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[tail_q] <= sel;
  end

endmodule
